// File: rtl/driver_display.sv
// ============================================================================
// Module  : driver_display
// Purpose : 8-digit multiplexed 7-segment driver, hex or decimal (double-dabble)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module driver_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] VALOR,
    input  logic        MODO,
    output logic [7:0]  ANODOS,
    output logic [6:0]  SEGMENTOS,
    output logic        BUSY
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_CONV = 2'd1;
    localparam logic [1:0] c_S_LOAD = 2'd2;

    localparam int              c_PW        = $clog2(REFRESH_DIV);
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(REFRESH_DIV - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [3:0]      r_cnt;
    logic [19:0]     r_bcd;
    logic [15:0]     r_bin;
    logic [15:0]     r_cap_val;
    logic            r_cap_mode;
    logic            r_pending;
    logic [19:0]     r_digits;
    logic            r_dmode;
    logic [c_PW-1:0] r_presc;
    logic [2:0]      r_idx;

    logic            w_change;
    logic            w_capture;
    logic            w_step;
    logic            w_load;
    logic [19:0]     w_adj;
    logic [4:1]      w_nz;
    logic [3:0]      w_nib;
    logic            w_blank;
    logic [6:0]      w_seg;

    assign w_change = r_pending || ({VALOR, MODO} != {r_cap_val, r_cap_mode});

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE: if (w_change) w_next = c_S_CONV;
            c_S_CONV: if (r_cnt == 4'd15) w_next = c_S_LOAD;
            c_S_LOAD: w_next = c_S_IDLE;
            default:  w_next = c_S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        BUSY      = 1'b0;
        w_capture = 1'b0;
        w_step    = 1'b0;
        w_load    = 1'b0;
        case (r_state)
            c_S_IDLE: w_capture = w_change;
            c_S_CONV: begin
                BUSY   = 1'b1;
                w_step = 1'b1;
            end
            c_S_LOAD: begin
                BUSY   = 1'b1;
                w_load = 1'b1;
            end
            default: BUSY = 1'b0;
        endcase
    end

    // Double-dabble correction: +3 on every BCD nibble >= 5 before the shift
    generate
        for (genvar g = 0; g < 5; g++) begin : g_dd
            assign w_adj[g*4 +: 4] = (r_bcd[g*4 +: 4] >= 4'd5) ? r_bcd[g*4 +: 4] + 4'd3
                                                              : r_bcd[g*4 +: 4];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cap_val  <= 16'h0000;
            r_cap_mode <= 1'b0;
            r_pending  <= 1'b1;
            r_digits   <= 20'h00000;
            r_dmode    <= 1'b0;
            r_cnt      <= 4'd0;
            r_bcd      <= 20'h00000;
            r_bin      <= 16'h0000;
        end else begin
            if (w_capture) begin
                r_cap_val  <= VALOR;
                r_cap_mode <= MODO;
                r_pending  <= 1'b0;
                r_bcd      <= 20'h00000;
                r_bin      <= VALOR;
                r_cnt      <= 4'd0;
            end
            if (w_step) begin
                r_bcd <= {w_adj[18:0], r_bin[15]};
                r_bin <= {r_bin[14:0], 1'b0};
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_load) begin
                r_digits <= r_cap_mode ? r_bcd : {4'h0, r_cap_val};
                r_dmode  <= r_cap_mode;
            end
        end
    end

    // ---------------- Refresh scan ----------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_presc <= '0;
            r_idx   <= 3'd0;
        end else if (r_presc == c_PRESC_MAX) begin
            r_presc <= '0;
            r_idx   <= r_idx + 3'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // w_nz[i]: some digit among i..4 is non-zero (leading-zero suppression)
    assign w_nz[4] = |r_digits[19:16];
    assign w_nz[3] = w_nz[4] | (|r_digits[15:12]);
    assign w_nz[2] = w_nz[3] | (|r_digits[11:8]);
    assign w_nz[1] = w_nz[2] | (|r_digits[7:4]);

    always_comb begin
        w_nib   = 4'h0;
        w_blank = 1'b1;
        case (r_idx)
            3'd0: begin w_nib = r_digits[3:0];   w_blank = 1'b0;                end
            3'd1: begin w_nib = r_digits[7:4];   w_blank = r_dmode & ~w_nz[1];  end
            3'd2: begin w_nib = r_digits[11:8];  w_blank = r_dmode & ~w_nz[2];  end
            3'd3: begin w_nib = r_digits[15:12]; w_blank = r_dmode & ~w_nz[3];  end
            3'd4: begin w_nib = r_digits[19:16]; w_blank = ~r_dmode | ~w_nz[4]; end
            default: begin w_nib = 4'h0;         w_blank = 1'b1;                end
        endcase
    end

    always_comb begin
        w_seg = 7'h7F;
        case (w_nib)
            4'h0: w_seg = 7'h40;
            4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;
            4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;
            4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;
            4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;
            4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;
            4'hF: w_seg = 7'h0E;
            default: w_seg = 7'h7F;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ANODOS    <= 8'hFF;
            SEGMENTOS <= 7'h7F;
        end else begin
            ANODOS    <= w_blank ? 8'hFF : ~(8'h01 << r_idx);
            SEGMENTOS <= w_blank ? 7'h7F : w_seg;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_driver_display.sv
// ============================================================================
// Module  : tb_driver_display
// Purpose : directed, table-driven self-checking bench for driver_display
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_driver_display;

    typedef logic [7:0][6:0] disp_t;   // expected segments per digit, 7F = blank
    typedef struct {
        logic [15:0] val;
        logic        mode;
        disp_t       seg;
    } vec_t;

    logic        clk;
    logic        RESET;
    logic [15:0] VALOR;
    logic        MODO;
    logic [7:0]  ANODOS;
    logic [6:0]  SEGMENTOS;
    logic        BUSY;

    int checks   = 0;
    int failures = 0;
    int n        = 0;   // rising edges since reset release

    driver_display #(.REFRESH_DIV(4)) dut (
        .CLK       (clk),
        .RESET     (RESET),
        .VALOR     (VALOR),
        .MODO      (MODO),
        .ANODOS    (ANODOS),
        .SEGMENTOS (SEGMENTOS),
        .BUSY      (BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (RESET) n <= 0;
        else       n <= n + 1;
    end

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected display for the scan position that the previous edge presented
    task automatic check_disp(input disp_t d, input string name);
        int         k;
        logic [7:0] ea;
        logic [6:0] es;
        if (n == 0) begin
            ea = 8'hFF;
            es = 7'h7F;
        end else begin
            k  = ((n - 1) / 4) % 8;
            es = d[k];
            ea = (es == 7'h7F) ? 8'hFF : ~(8'h01 << k);
        end
        chk({ANODOS, SEGMENTOS} == {ea, es}, name,
            int'({ANODOS, 1'b0, SEGMENTOS}), int'({ea, 1'b0, es}));
    endtask

    task automatic scan(input disp_t d, input string name);
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            check_disp(d, name);
        end
    endtask

    // Entered at the negedge right after the capture edge
    task automatic wait_conv(input disp_t old_d, input disp_t new_d,
                             input int chg_at, input logic [15:0] chg_val);
        int cnt;
        cnt = 0;
        while (BUSY === 1'b1 && cnt < 40) begin
            cnt++;
            if (cnt == chg_at) VALOR = chg_val;
            @(negedge clk);
        end
        chk(cnt == 17, "busy_len", cnt, 17);
        check_disp(old_d, "hold_old_at_17");
        @(negedge clk);
        check_disp(new_d, "new_at_18");
    endtask

    vec_t  vecs [7];
    disp_t zero_hex, d100, d7, dA5C9, prev;

    initial begin
        zero_hex = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40};
        vecs[0] = '{16'd1234,  1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{16'hFFFF,  1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h02, 7'h12, 7'h12, 7'h30, 7'h12}};
        vecs[2] = '{16'hBEEF,  1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h03, 7'h06, 7'h06, 7'h0E}};
        vecs[3] = '{16'd0,     1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[4] = '{16'd1000,  1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40}};
        vecs[5] = '{16'h0012,  1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h79, 7'h24}};
        vecs[6] = '{16'd10000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40}};
        d100  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40};
        d7    = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78};
        dA5C9 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12, 7'h46, 7'h10};

        // Reset with the first value already applied: pending flag must start it
        RESET = 1'b1;
        VALOR = vecs[0].val;
        MODO  = vecs[0].mode;
        repeat (3) @(negedge clk);
        chk(BUSY == 1'b0,         "rst_busy", int'(BUSY), 0);
        chk(ANODOS == 8'hFF,      "rst_anodos", int'(ANODOS), 'hFF);
        chk(SEGMENTOS == 7'h7F,   "rst_seg", int'(SEGMENTOS), 'h7F);
        RESET = 1'b0;
        @(negedge clk);
        chk(BUSY == 1'b1, "pending_start", int'(BUSY), 1);
        wait_conv(zero_hex, vecs[0].seg, 0, 16'h0);
        scan(vecs[0].seg, "scan_v0");
        prev = vecs[0].seg;

        for (int v = 1; v < 7; v++) begin
            @(negedge clk);
            VALOR = vecs[v].val;
            MODO  = vecs[v].mode;
            @(negedge clk);
            wait_conv(prev, vecs[v].seg, 0, 16'h0);
            scan(vecs[v].seg, "scan_vec");
            prev = vecs[v].seg;
        end

        // Input change during CONV cycle 5 is picked up on return to IDLE
        @(negedge clk);
        VALOR = 16'd100;
        MODO  = 1'b1;
        @(negedge clk);
        wait_conv(prev, d100, 5, 16'd7);
        chk(BUSY == 1'b1, "reconv_start", int'(BUSY), 1);
        wait_conv(d100, d7, 0, 16'h0);
        scan(d7, "scan_7");

        // Reset in CONV cycle 8: abort, digits cleared, fresh conversion after release
        @(negedge clk);
        VALOR = 16'hA5C9;
        MODO  = 1'b0;
        @(negedge clk);
        repeat (7) @(negedge clk);
        RESET = 1'b1;
        @(negedge clk);
        chk(BUSY == 1'b0,       "midrst_busy", int'(BUSY), 0);
        chk(ANODOS == 8'hFF,    "midrst_anodos", int'(ANODOS), 'hFF);
        chk(SEGMENTOS == 7'h7F, "midrst_seg", int'(SEGMENTOS), 'h7F);
        @(negedge clk);
        RESET = 1'b0;
        @(negedge clk);
        chk(BUSY == 1'b1, "postrst_start", int'(BUSY), 1);
        check_disp(zero_hex, "postrst_cleared");
        wait_conv(zero_hex, dA5C9, 0, 16'h0);
        scan(dA5C9, "scan_a5c9");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
